// File: rtl/seq_mult_ctrl_if.sv
// Operand/result bundle for the sequential multiplier.
// No latency of its own; carries start/busy/done and the product halves.
// The issuing stage must hold off new work while busy is high.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic             hi_nz;

  // Issuing stage drives operands and start, observes status and result.
  modport master (
    output start, op_a, op_b,
    input  busy, done, prod_hi, prod_lo, hi_nz
  );

  // Multiplier samples operands and start, drives status and result.
  modport slave (
    input  start, op_a, op_b,
    output busy, done, prod_hi, prod_lo, hi_nz
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Shift-add unsigned multiplier: one WIDTH-bit adder reused over WIDTH steps.
// Latency: done pulses WIDTH edges after the accepting edge; result held until next completion.
// Backpressure: start is ignored while busy; a start seen in DONE is accepted with no bubble.
module seq_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] mplr_nxt;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] prod_hi_q;
  logic [WIDTH-1:0] prod_lo_q;
  logic             hi_nz_q;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: accept from IDLE or DONE, finish after the last step.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add step. acc[WIDTH] is always zero after a shift, so adding the
  // whole acc equals adding its low WIDTH bits; the sum keeps the carry bit.
  always_comb begin
    sum = mplr[0] ? (acc + {1'b0, mcand}) : acc;
    {acc_nxt, mplr_nxt} = {sum, mplr} >> 1;
  end

  // Working registers: load on accept, step every BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= bus.op_a;
      mplr  <= bus.op_b;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == BUSY) begin
      mplr  <= mplr_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt + 1'b1;
    end
  end

  // Result registers change only on the completing edge, so the product stays
  // readable through a following accept and the whole next BUSY phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      hi_nz_q   <= 1'b0;
    end else if (last_step) begin
      prod_hi_q <= acc_nxt[WIDTH-1:0];
      prod_lo_q <= mplr_nxt;
      hi_nz_q   <= (acc_nxt[WIDTH-1:0] != '0);
    end
  end

  assign bus.busy    = (state == BUSY);
  assign bus.done    = (state == DONE);
  assign bus.prod_hi = prod_hi_q;
  assign bus.prod_lo = prod_lo_q;
  assign bus.hi_nz   = hi_nz_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is high.
// Directed vectors first, then random pairs against a 64-bit reference product.
module tb_seq_mult_ctrl;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        nz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  // Edge counter used to timestamp expected done cycles.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic exp_t make_exp(input logic [31:0] a, input logic [31:0] b,
                                    input int c, input string name);
    exp_t e;
    logic [63:0] p;
    p      = {32'd0, a} * {32'd0, b};
    e.hi   = p[63:32];
    e.lo   = p[31:0];
    e.nz   = (p[63:32] != 32'd0);
    e.cyc  = c;
    e.name = name;
    return e;
  endfunction

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done high at cycle %0d, required no pending op", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_product"}, {bus.prod_hi, bus.prod_lo}, {mon_e.hi, mon_e.lo});
        check({mon_e.name, "_hi_nz"}, 64'(bus.hi_nz), 64'(mon_e.nz));
        check({mon_e.name, "_done_cycle"}, 64'(cyc), 64'(mon_e.cyc));
        check({mon_e.name, "_busy_low"}, 64'(bus.busy), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.done) && n < 100);
    if (bus.busy || bus.done) begin
      n_checks++;
      $display("FAIL wait_idle_timeout: busy=%0b done=%0b, required idle", bus.busy, bus.done);
    end
  endtask

  // Drive a one-cycle start at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input string name);
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    exp_q.push_back(make_exp(a, b, cyc + 33, name));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int dc0;
    int n;
    logic [31:0] ra, rb;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod_hi", 64'(bus.prod_hi), 64'd0);
    check("rst_prod_lo", 64'(bus.prod_lo), 64'd0);
    check("rst_hi_nz", 64'(bus.hi_nz), 64'd0);
    rst_n = 1'b1;

    // 3 * 5 and busy duration.
    wait_idle();
    issue(32'd3, 32'd5, "mul3x5");
    nb = 0;
    @(negedge clk);
    while (bus.busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(nb), 64'd32);

    // Carry retention: all-ones squared = FFFFFFFE_00000001.
    wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");

    // Start during BUSY is ignored; previous product holds through BUSY.
    wait_idle();
    dc0 = done_cnt;
    issue(32'd1000, 32'd1000, "ignored_start");
    repeat (9) @(posedge clk);
    #1;
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("hold_prod_hi", 64'(bus.prod_hi), 64'hFFFF_FFFE);
    check("hold_prod_lo", 64'(bus.prod_lo), 64'h0000_0001);
    check("hold_hi_nz", 64'(bus.hi_nz), 64'd1);
    wait_idle();
    check("single_done_pulse", 64'(done_cnt - dc0), 64'd1);

    // 0x80000000 * 2 = 1_00000000, then zero operand.
    issue(32'h8000_0000, 32'd2, "msb_x2");
    wait_idle();
    issue(32'd0, 32'h1234_5678, "zero_a");
    wait_idle();

    // Back-to-back: start held through DONE, new operands accepted on DONE exit.
    @(negedge clk);
    bus.op_a  = 32'd6;
    bus.op_b  = 32'd7;
    bus.start = 1'b1;
    exp_q.push_back(make_exp(32'd6, 32'd7, cyc + 33, "b2b_first"));
    exp_q.push_back(make_exp(32'd7, 32'd9, cyc + 66, "b2b_second"));
    @(posedge clk);
    #1;
    bus.op_a = 32'd7;
    bus.op_b = 32'd9;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    if (!bus.done) begin
      n_checks++;
      $display("FAIL b2b_done_timeout: done=%0b, required 1", bus.done);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();

    // Reset in the middle of BUSY aborts the operation.
    issue(32'h1234_5678, 32'd2, "aborted");
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_prod_hi", 64'(bus.prod_hi), 64'd0);
    check("abort_prod_lo", 64'(bus.prod_lo), 64'd0);
    check("abort_hi_nz", 64'(bus.hi_nz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (50) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt - dc0), 64'd0);
    issue(32'h0000_FFFF, 32'h0000_FFFF, "after_reset");
    wait_idle();

    // Random unsigned pairs against the reference product.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) ra = ra >> $urandom_range(31, 0);
      issue(ra, rb, "random");
      wait_idle();
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
